// File: rtl/timer_record_store_pkg.sv
// Shared definitions for the stopwatch lap/record store: digit geometry and
// display-mode state encoding.
package timer_record_store_pkg;

  localparam int unsigned DIGW = 4;
  localparam int unsigned NDIG = 4;
  localparam int unsigned RECW = DIGW * NDIG;

  // LIVE shows the running time, RECALL shows a stored record.
  typedef enum logic {
    StLive   = 1'b0,
    StRecall = 1'b1
  } rec_state_e;

endpackage

// File: rtl/timer_record_store_edge_pulse.sv
// Single-bit rising-edge detector: one-cycle pulse when the sampled level goes
// from 0 to 1. A held level produces a single pulse.
module timer_record_store_edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev_q;

  // Remember last cycle's sample of the button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  // Pulse while the current sample is high and the previous one was low.
  always_comb begin
    pulse = level & ~prev_q;
  end

endmodule

// File: rtl/timer_record_store.sv
// Lap/record store: captures the live MM:SS digits into a circular buffer and
// replays them newest-first on recall presses, driving the display mux select.
module timer_record_store
  import timer_record_store_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RECW-1:0]            live_digits,
  input  logic                       cap_btn,
  input  logic                       recall_btn,
  input  logic                       clear_btn,
  output logic [RECW-1:0]            rec_digits,
  output logic                       mux_sel,
  output logic [$clog2(DEPTH)-1:0]   rec_idx,
  output logic [$clog2(DEPTH):0]     rec_count,
  output logic                       full
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  logic cap_p, rec_p, clr_p;

  rec_state_e          state_q, state_d;
  logic [IdxW-1:0]     wr_q, wr_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RECW-1:0]     dig_q, dig_d;
  logic                we;
  logic [RECW-1:0]     buf_q [DEPTH];
  logic [IdxW-1:0]     newest;
  logic                is_full;

  timer_record_store_edge_pulse u_cap_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (cap_btn),
    .pulse (cap_p)
  );

  timer_record_store_edge_pulse u_rec_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (recall_btn),
    .pulse (rec_p)
  );

  timer_record_store_edge_pulse u_clr_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (clear_btn),
    .pulse (clr_p)
  );

  // Next-state logic; clear beats capture, capture beats recall.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    we      = 1'b0;
    newest  = wr_q - IdxW'(1);
    is_full = (cnt_q == CntW'(DEPTH));
    if (clr_p) begin
      state_d = StLive;
      wr_d    = '0;
      idx_d   = '0;
      cnt_d   = '0;
      dig_d   = '0;
    end else begin
      unique case (state_q)
        StLive: begin
          if (cap_p) begin
            // A simultaneous recall press is dropped, not queued.
            we   = 1'b1;
            wr_d = wr_q + IdxW'(1);
            if (!is_full) cnt_d = cnt_q + CntW'(1);
          end else if (rec_p && cnt_q != '0) begin
            state_d = StRecall;
            idx_d   = '0;
            dig_d   = buf_q[newest];
          end
        end
        StRecall: begin
          if (rec_p) begin
            if ({1'b0, idx_q} < cnt_q - CntW'(1)) begin
              idx_d = idx_q + IdxW'(1);
              dig_d = buf_q[newest - idx_d];
            end else begin
              // Oldest entry was on show: back to live, digits hold.
              state_d = StLive;
              idx_d   = '0;
            end
          end
        end
        default: state_d = StLive;
      endcase
    end
  end

  // FSM, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLive;
      wr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
    end
  end

  // Record storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) buf_q[wr_q] <= live_digits;
  end

  // Drive ports from the registered state.
  always_comb begin
    rec_digits = dig_q;
    mux_sel    = (state_q == StRecall);
    rec_idx    = idx_q;
    rec_count  = cnt_q;
    full       = (cnt_q == CntW'(DEPTH));
  end

endmodule

// File: tb/tb_timer_record_store.sv
// Directed bench for timer_record_store with DEPTH=4.
module tb_timer_record_store;

  logic        clk;
  logic        rst_n;
  logic [15:0] live_digits;
  logic        cap_btn;
  logic        recall_btn;
  logic        clear_btn;
  logic [15:0] rec_digits;
  logic        mux_sel;
  logic [1:0]  rec_idx;
  logic [2:0]  rec_count;
  logic        full;

  int n_tests = 0;
  int n_fail  = 0;

  timer_record_store #(
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .live_digits (live_digits),
    .cap_btn     (cap_btn),
    .recall_btn  (recall_btn),
    .clear_btn   (clear_btn),
    .rec_digits  (rec_digits),
    .mux_sel     (mux_sel),
    .rec_idx     (rec_idx),
    .rec_count   (rec_count),
    .full        (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_cap(input logic [15:0] d);
    live_digits = d;
    cap_btn = 1'b1;
    tick();
    cap_btn = 1'b0;
    tick();
  endtask

  task automatic press_rec();
    recall_btn = 1'b1;
    tick();
    recall_btn = 1'b0;
    tick();
  endtask

  task automatic press_clr();
    clear_btn = 1'b1;
    tick();
    clear_btn = 1'b0;
    tick();
  endtask

  task automatic check_view(input string tag, input logic sel, input logic [15:0] dig,
                            input logic [1:0] idx);
    check({tag, ".mux"}, 32'(mux_sel), 32'(sel));
    check({tag, ".dig"}, 32'(rec_digits), 32'(dig));
    check({tag, ".idx"}, 32'(rec_idx), 32'(idx));
  endtask

  initial begin
    rst_n       = 1'b0;
    live_digits = 16'h0000;
    cap_btn     = 1'b0;
    recall_btn  = 1'b0;
    clear_btn   = 1'b0;

    // 1: reset then idle
    #12;
    rst_n = 1'b1;
    tick();
    check_view("rst", 1'b0, 16'h0000, 2'd0);
    check("rst.cnt", 32'(rec_count), 32'd0);
    check("rst.full", 32'(full), 32'd0);
    press_rec();
    check_view("empty_rec", 1'b0, 16'h0000, 2'd0);
    check("empty_rec.cnt", 32'(rec_count), 32'd0);

    // 2: two captures, recall newest first, then back to live
    press_cap(16'h1234);
    check("cap1.cnt", 32'(rec_count), 32'd1);
    press_cap(16'h0559);
    check("cap2.cnt", 32'(rec_count), 32'd2);
    check("cap2.mux", 32'(mux_sel), 32'd0);
    press_rec();
    check_view("t2.r0", 1'b1, 16'h0559, 2'd0);
    press_rec();
    check_view("t2.r1", 1'b1, 16'h1234, 2'd1);
    press_rec();
    check_view("t2.back", 1'b0, 16'h1234, 2'd0);

    // 3: overfill DEPTH=4 with five records
    press_clr();
    check("t3.clr.cnt", 32'(rec_count), 32'd0);
    check("t3.clr.dig", 32'(rec_digits), 32'h0);
    for (int i = 1; i <= 5; i++) press_cap(16'(i));
    check("t3.cnt", 32'(rec_count), 32'd4);
    check("t3.full", 32'(full), 32'd1);
    press_rec();
    check_view("t3.r0", 1'b1, 16'h0005, 2'd0);
    press_rec();
    check_view("t3.r1", 1'b1, 16'h0004, 2'd1);
    press_rec();
    check_view("t3.r2", 1'b1, 16'h0003, 2'd2);
    press_rec();
    check_view("t3.r3", 1'b1, 16'h0002, 2'd3);
    press_rec();
    check_view("t3.back", 1'b0, 16'h0002, 2'd0);
    check("t3.back.cnt", 32'(rec_count), 32'd4);

    // 4: simultaneous capture+recall in LIVE, then held capture
    press_clr();
    live_digits = 16'h0777;
    cap_btn = 1'b1;
    recall_btn = 1'b1;
    tick();
    check("t4.both.cnt", 32'(rec_count), 32'd1);
    check("t4.both.mux", 32'(mux_sel), 32'd0);
    cap_btn = 1'b0;
    recall_btn = 1'b0;
    tick();
    check("t4.norequeue.mux", 32'(mux_sel), 32'd0);
    live_digits = 16'h0888;
    cap_btn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    cap_btn = 1'b0;
    tick();
    check("t4.held.cnt", 32'(rec_count), 32'd2);
    check("t4.held.full", 32'(full), 32'd0);
    press_rec();
    check_view("t4.r0", 1'b1, 16'h0888, 2'd0);
    press_rec();
    check_view("t4.r1", 1'b1, 16'h0777, 2'd1);

    // capture is ignored in RECALL
    press_cap(16'h0999);
    check_view("t4.capinrec", 1'b1, 16'h0777, 2'd1);
    check("t4.capinrec.cnt", 32'(rec_count), 32'd2);

    // 5: clear from RECALL at idx=1
    press_clr();
    check_view("t5.clr", 1'b0, 16'h0000, 2'd0);
    check("t5.clr.cnt", 32'(rec_count), 32'd0);
    press_rec();
    check_view("t5.rec", 1'b0, 16'h0000, 2'd0);
    check("t5.rec.cnt", 32'(rec_count), 32'd0);

    // 6: asynchronous reset mid-RECALL between clock edges
    press_cap(16'h0123);
    press_rec();
    check_view("t6.pre", 1'b1, 16'h0123, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_view("t6.async", 1'b0, 16'h0000, 2'd0);
    check("t6.async.cnt", 32'(rec_count), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("t6.after.cnt", 32'(rec_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
